// File: rtl/alu_scheduler_if.sv
// Bundles the requester, ALU and response channels of alu_scheduler.
// The master side is the environment (requesters, ALU, response sink).
// The slave side is the scheduler itself.
interface alu_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
);

  // Requester side
  logic [NUM_REQ-1:0]            ReqValid;
  logic [NUM_REQ-1:0]            ReqReady;
  logic [4*NUM_REQ-1:0]          ReqOperator;
  logic [DATA_WIDTH*NUM_REQ-1:0] ReqInput1;
  logic [DATA_WIDTH*NUM_REQ-1:0] ReqInput2;

  // Shared ALU side
  logic [DATA_WIDTH-1:0]         AluInput1;
  logic [DATA_WIDTH-1:0]         AluInput2;
  logic [3:0]                    AluOperator;
  logic [DATA_WIDTH-1:0]         AluResult;
  logic                          AluCarry;

  // Response side
  logic                          RspValid;
  logic                          RspReady;
  logic [ID_WIDTH-1:0]           RspId;
  logic [DATA_WIDTH-1:0]         RspResult;
  logic                          RspCarry;
  logic                          RspDivZero;

  // Status
  logic                          Busy;

  modport master (
    output ReqValid, ReqOperator, ReqInput1, ReqInput2,
    output AluResult, AluCarry,
    output RspReady,
    input  ReqReady,
    input  AluInput1, AluInput2, AluOperator,
    input  RspValid, RspId, RspResult, RspCarry, RspDivZero,
    input  Busy
  );

  modport slave (
    input  ReqValid, ReqOperator, ReqInput1, ReqInput2,
    input  AluResult, AluCarry,
    input  RspReady,
    output ReqReady,
    output AluInput1, AluInput2, AluOperator,
    output RspValid, RspId, RspResult, RspCarry, RspDivZero,
    output Busy
  );

endinterface

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one external combinational ALU among
// NUM_REQ requesters. One operation is in flight at a time:
// IDLE (arbitrate and latch operands) -> EXEC (ALU settles, capture result)
// -> RESP (hold response until accepted).
module alu_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_scheduler_if.slave bus
);

  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   gnt_id_q, gnt_id_d;
  logic                  div_z_q, div_z_d;
  logic [DATA_WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [DATA_WIDTH-1:0] alu_in2_q, alu_in2_d;
  logic [3:0]            alu_op_q, alu_op_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_carry_q, rsp_carry_d;
  logic                  rsp_div_zero_q, rsp_div_zero_d;

  // Arbiter results
  logic                  found;
  logic [ID_WIDTH-1:0]   grant;
  logic [ID_WIDTH-1:0]   idx;
  int                    idx_int;

  // Slice of the granted requester
  logic [3:0]            sel_op;
  logic [DATA_WIDTH-1:0] sel_in1;
  logic [DATA_WIDTH-1:0] sel_in2;

  // Round-robin search: first valid request at or after ptr_q, wrapping.
  // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    found   = 1'b0;
    grant   = '0;
    idx     = '0;
    idx_int = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_int = int'(ptr_q) + k;
      if (idx_int >= NUM_REQ) begin
        idx_int = idx_int - NUM_REQ;
      end
      idx = ID_WIDTH'(idx_int);
      if (!found && bus.ReqValid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Operand/operator slice of the granted requester.
  always_comb begin
    sel_op  = bus.ReqOperator[4*grant +: 4];
    sel_in1 = bus.ReqInput1[DATA_WIDTH*grant +: DATA_WIDTH];
    sel_in2 = bus.ReqInput2[DATA_WIDTH*grant +: DATA_WIDTH];
  end

  // Accept strobe: one-hot on the grant, only while idle and out of reset.
  always_comb begin
    bus.ReqReady = '0;
    if (state_q == IDLE && found && !rst_i) begin
      bus.ReqReady = NUM_REQ'(1) << grant;
    end
  end

  // Next-state and datapath update for the three-state sequencer.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_id_d       = gnt_id_q;
    div_z_d        = div_z_q;
    alu_in1_d      = alu_in1_q;
    alu_in2_d      = alu_in2_q;
    alu_op_d       = alu_op_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_div_zero_d = rsp_div_zero_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          alu_in1_d = sel_in1;
          alu_in2_d = sel_in2;
          alu_op_d  = sel_op;
          gnt_id_d  = grant;
          div_z_d   = (sel_op == OP_DIV) && (sel_in2 == '0);
          ptr_d     = (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          state_d   = EXEC;
        end
      end

      EXEC: begin
        // Divide by zero reports all ones with no carry, whatever the ALU says.
        rsp_result_d   = div_z_q ? '1 : bus.AluResult;
        rsp_carry_d    = div_z_q ? 1'b0 : bus.AluCarry;
        rsp_div_zero_d = div_z_q;
        rsp_id_d       = gnt_id_q;
        rsp_valid_d    = 1'b1;
        state_d        = RESP;
      end

      RESP: begin
        if (bus.RspReady) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      gnt_id_q       <= '0;
      div_z_q        <= 1'b0;
      alu_in1_q      <= '0;
      alu_in2_q      <= '0;
      alu_op_q       <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_div_zero_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gnt_id_q       <= gnt_id_d;
      div_z_q        <= div_z_d;
      alu_in1_q      <= alu_in1_d;
      alu_in2_q      <= alu_in2_d;
      alu_op_q       <= alu_op_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_div_zero_q <= rsp_div_zero_d;
    end
  end

  // Registered outputs.
  always_comb begin
    bus.AluInput1   = alu_in1_q;
    bus.AluInput2   = alu_in2_q;
    bus.AluOperator = alu_op_q;
    bus.RspValid    = rsp_valid_q;
    bus.RspId       = rsp_id_q;
    bus.RspResult   = rsp_result_q;
    bus.RspCarry    = rsp_carry_q;
    bus.RspDivZero  = rsp_div_zero_q;
    bus.Busy        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a small behavioural ALU model.
module tb_alu_scheduler;

  localparam int DW = 8;
  localparam int NR = 4;

  logic clk;
  logic rst;

  int total_checks;
  int passed_checks;
  int failed_checks;

  alu_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  alu_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: carry is always the add carry of the operands.
  logic [DW:0] alu_sum;
  assign alu_sum       = {1'b0, bus.AluInput1} + {1'b0, bus.AluInput2};
  assign bus.AluCarry  = alu_sum[DW];
  assign bus.AluResult =
      (bus.AluOperator == 4'b0000) ? alu_sum[DW-1:0] :
      (bus.AluOperator == 4'b0001) ? bus.AluInput1 - bus.AluInput2 :
      (bus.AluOperator == 4'b0010) ? DW'(bus.AluInput1 * bus.AluInput2) :
      (bus.AluOperator == 4'b0011) ? ((bus.AluInput2 == '0) ? 8'h00 : bus.AluInput1 / bus.AluInput2) :
                                     bus.AluInput1 & bus.AluInput2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else begin
      failed_checks++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.ReqOperator[4*i +: 4] = op;
    bus.ReqInput1[DW*i +: DW] = a;
    bus.ReqInput2[DW*i +: DW] = b;
  endtask

  // One full operation with RspReady high: expects grant g, then the given response.
  task automatic do_op(input string tag, input int g, input logic [7:0] res,
                       input logic c, input logic dz);
    #1;
    check({tag, " ready"}, 32'(bus.ReqReady), 32'(1 << g));
    check({tag, " idle busy"}, 32'(bus.Busy), 32'd0);
    tick();
    check({tag, " exec ready"}, 32'(bus.ReqReady), 32'd0);
    check({tag, " exec busy"}, 32'(bus.Busy), 32'd1);
    check({tag, " exec rspvalid"}, 32'(bus.RspValid), 32'd0);
    tick();
    check({tag, " rspvalid"}, 32'(bus.RspValid), 32'd1);
    check({tag, " rspid"}, 32'(bus.RspId), 32'(g));
    check({tag, " result"}, 32'(bus.RspResult), 32'(res));
    check({tag, " carry"}, 32'(bus.RspCarry), 32'(c));
    check({tag, " divzero"}, 32'(bus.RspDivZero), 32'(dz));
    tick();
    check({tag, " done rspvalid"}, 32'(bus.RspValid), 32'd0);
    check({tag, " done busy"}, 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    failed_checks = 0;

    rst             = 1'b1;
    bus.ReqValid    = '0;
    bus.ReqOperator = '0;
    bus.ReqInput1   = '0;
    bus.ReqInput2   = '0;
    bus.RspReady    = 1'b0;

    // Reset state
    #1;
    check("rst rspvalid", 32'(bus.RspValid), 32'd0);
    check("rst busy", 32'(bus.Busy), 32'd0);
    check("rst aluin1", 32'(bus.AluInput1), 32'd0);
    check("rst aluop", 32'(bus.AluOperator), 32'd0);
    check("rst rspresult", 32'(bus.RspResult), 32'd0);
    check("rst ready", 32'(bus.ReqReady), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single add on requester 0: F0 + 20 = 110
    set_req(0, 4'b0000, 8'hF0, 8'h20);
    bus.ReqValid = 4'b0001;
    bus.RspReady = 1'b1;
    #1;
    check("t1 ready", 32'(bus.ReqReady), 32'h1);
    tick();
    bus.ReqValid = 4'b0000;
    #1;
    check("t1 aluin1", 32'(bus.AluInput1), 32'hF0);
    check("t1 aluin2", 32'(bus.AluInput2), 32'h20);
    check("t1 aluop", 32'(bus.AluOperator), 32'h0);
    check("t1 busy", 32'(bus.Busy), 32'd1);
    tick();
    check("t1 rspvalid", 32'(bus.RspValid), 32'd1);
    check("t1 result", 32'(bus.RspResult), 32'h10);
    check("t1 carry", 32'(bus.RspCarry), 32'd1);
    check("t1 id", 32'(bus.RspId), 32'd0);
    check("t1 divzero", 32'(bus.RspDivZero), 32'd0);
    tick();
    check("t1 done rspvalid", 32'(bus.RspValid), 32'd0);
    check("t1 done busy", 32'(bus.Busy), 32'd0);

    // Requester 3 alone moves the pointer from 1 to 0 (wrap): 80 + 80 = 100
    set_req(3, 4'b0000, 8'h80, 8'h80);
    bus.ReqValid = 4'b1000;
    do_op("wrap3", 3, 8'h00, 1'b1, 1'b0);
    bus.ReqValid = 4'b0000;

    // All four requesting: grants 0,1,2,3,0,1
    for (int i = 0; i < NR; i++) begin
      set_req(i, 4'b0000, 8'(8'h10 * (i + 1)), 8'(i + 1));
    end
    bus.ReqValid = 4'b1111;
    do_op("rr0", 0, 8'h11, 1'b0, 1'b0);
    do_op("rr1", 1, 8'h22, 1'b0, 1'b0);
    do_op("rr2", 2, 8'h33, 1'b0, 1'b0);
    do_op("rr3", 3, 8'h44, 1'b0, 1'b0);
    do_op("rr4", 0, 8'h11, 1'b0, 1'b0);
    do_op("rr5", 1, 8'h22, 1'b0, 1'b0);
    bus.ReqValid = 4'b0000;

    // Pointer at 2, only 1 and 3 valid: grant 3, then 1
    set_req(3, 4'b0000, 8'hFF, 8'h01);
    set_req(1, 4'b0000, 8'h12, 8'h34);
    bus.ReqValid = 4'b1010;
    do_op("skip3", 3, 8'h00, 1'b1, 1'b0);
    do_op("skip1", 1, 8'h46, 1'b0, 1'b0);
    bus.ReqValid = 4'b0000;

    // Divide cases on requester 2
    set_req(2, 4'b0011, 8'h55, 8'h00);
    bus.ReqValid = 4'b0100;
    do_op("div0", 2, 8'hFF, 1'b0, 1'b1);
    set_req(2, 4'b0011, 8'h55, 8'h05);
    do_op("div5", 2, 8'h11, 1'b0, 1'b0);
    set_req(2, 4'b0011, 8'hF0, 8'h20);
    do_op("divcarry", 2, 8'h07, 1'b1, 1'b0);
    bus.ReqValid = 4'b0000;

    // Back-pressure: sub 50 - 10 = 40, RspReady low for 5 cycles
    set_req(0, 4'b0001, 8'h50, 8'h10);
    bus.ReqValid = 4'b0001;
    bus.RspReady = 1'b0;
    #1;
    check("bp ready", 32'(bus.ReqReady), 32'h1);
    tick();
    bus.ReqValid = 4'b0010;
    set_req(0, 4'b0001, 8'h99, 8'h99);
    #1;
    check("bp exec ready", 32'(bus.ReqReady), 32'd0);
    check("bp aluin1", 32'(bus.AluInput1), 32'h50);
    tick();
    check("bp rspvalid", 32'(bus.RspValid), 32'd1);
    check("bp result", 32'(bus.RspResult), 32'h40);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp hold rspvalid", 32'(bus.RspValid), 32'd1);
      check("bp hold result", 32'(bus.RspResult), 32'h40);
      check("bp hold carry", 32'(bus.RspCarry), 32'd0);
      check("bp hold id", 32'(bus.RspId), 32'd0);
      check("bp hold ready", 32'(bus.ReqReady), 32'd0);
      check("bp hold busy", 32'(bus.Busy), 32'd1);
      check("bp hold aluin1", 32'(bus.AluInput1), 32'h50);
    end
    bus.RspReady = 1'b1;
    bus.ReqValid = 4'b0000;
    tick();
    check("bp release rspvalid", 32'(bus.RspValid), 32'd0);
    check("bp release busy", 32'(bus.Busy), 32'd0);

    // Asynchronous reset while in EXEC
    set_req(1, 4'b0000, 8'h01, 8'h02);
    bus.ReqValid = 4'b0010;
    tick();
    check("ar exec busy", 32'(bus.Busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar busy", 32'(bus.Busy), 32'd0);
    check("ar aluin1", 32'(bus.AluInput1), 32'd0);
    check("ar aluin2", 32'(bus.AluInput2), 32'd0);
    check("ar rspvalid", 32'(bus.RspValid), 32'd0);
    check("ar ready", 32'(bus.ReqReady), 32'd0);
    tick();
    rst = 1'b0;
    bus.ReqValid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ar no response", 32'(bus.RspValid), 32'd0);
    end
    bus.ReqValid = 4'b1111;
    #1;
    check("ar first grant", 32'(bus.ReqReady), 32'h1);
    bus.ReqValid = 4'b0000;
    #1;

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
